// File: rtl/bp_update_scheduler_if.sv
// rtl/bp_update_scheduler_if.sv - branch-predictor update scheduler bus interface
//
// Purpose : bundles the resolving-branch enqueue side and the BTB/PHT write
//           side of bp_update_scheduler.
// Signals : upd_valid/upd_pc/upd_target/upd_taken/upd_ready - per-source enqueue
//           flush                                           - discard queued updates
//           wr_valid/wr_clear/wr_index/wr_pc/wr_target/
//           wr_taken/wr_ready                               - BTB write request
//           count                                           - queued entries
// Modports: slave (scheduler side), master (producer/BTB side)
interface bp_update_scheduler_if #(
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 8,
   parameter int BTB_SETS = 64
);
   localparam int IDXW = $clog2(BTB_SETS);
   localparam int CW   = $clog2(DEPTH + 1);

   logic [NUM_SRC-1:0]         upd_valid;
   logic [NUM_SRC-1:0][31:0]   upd_pc;
   logic [NUM_SRC-1:0][31:0]   upd_target;
   logic [NUM_SRC-1:0]         upd_taken;
   logic                       upd_ready;
   logic                       flush;
   logic                       wr_valid;
   logic                       wr_clear;
   logic [IDXW-1:0]            wr_index;
   logic [31:0]                wr_pc;
   logic [31:0]                wr_target;
   logic                       wr_taken;
   logic                       wr_ready;
   logic [CW-1:0]              count;

   modport slave (
      input  upd_valid, upd_pc, upd_target, upd_taken, flush, wr_ready,
      output upd_ready, wr_valid, wr_clear, wr_index, wr_pc, wr_target, wr_taken, count
   );

   modport master (
      output upd_valid, upd_pc, upd_target, upd_taken, flush, wr_ready,
      input  upd_ready, wr_valid, wr_clear, wr_index, wr_pc, wr_target, wr_taken, count
   );
endinterface

// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - queues resolved branches and schedules BTB/PHT writes
//
// Purpose : after reset, sweeps every BTB set with clear writes; afterwards
//           accepts up to NUM_SRC resolved branches per cycle into a DEPTH-entry
//           circular queue and writes them to the BTB in order.
// Ports   : clock - single clock, all state changes on posedge
//           reset - asynchronous, active-high
//           bus   - bp_update_scheduler_if.slave (enqueue side, write side, count)
// Config  : define BP_UPD_COALESCE_EN to merge an update whose PC matches the
//           current tail entry into that entry instead of allocating a new one.
module bp_update_scheduler #(
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 8,
   parameter int BTB_SETS = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   bp_update_scheduler_if.slave    bus
);
   localparam int IDXW = $clog2(BTB_SETS);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = $clog2(DEPTH + 1);
   localparam logic [IDXW-1:0] LAST_SET = IDXW'(BTB_SETS - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_DRAIN} state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [IDXW-1:0]   r_sweep;
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;

   logic [31:0]       r_q_pc  [DEPTH];
   logic [31:0]       r_q_tgt [DEPTH];
   logic              r_q_tkn [DEPTH];

   logic              w_room;
   logic              w_upd_ready;
   logic              w_flush;
   logic              w_deq;
   logic [CW-1:0]     w_n_alloc;
   logic [CW-1:0]     w_cnt_next;
   logic              w_wr   [NUM_SRC];
   logic [PW-1:0]     w_slot [NUM_SRC];

`ifdef BP_UPD_COALESCE_EN
   logic              w_last_ok;
   logic [31:0]       w_last_pc;
   logic [PW-1:0]     w_last_slot;
   logic [PW-1:0]     w_tail_m1;
`endif

   // Readiness ignores any same-cycle dequeue so it depends only on registered state.
   assign w_room      = (DEPTH - int'(r_count)) >= NUM_SRC;
   assign w_upd_ready = !reset && (r_state != S_INIT) && w_room;
   assign w_flush     = bus.flush && (r_state != S_INIT);
   assign w_deq       = (r_state == S_DRAIN) && bus.wr_ready;

   // Slot assignment: accepted sources allocate contiguously at the tail in
   // source order; with coalescing, a PC match against the youngest entry
   // (existing tail or one allocated earlier this cycle) rewrites that slot.
   always_comb begin
      w_n_alloc = '0;
`ifdef BP_UPD_COALESCE_EN
      w_tail_m1   = PW'(r_tail - PW'(1));
      // The tail entry may not be merged into while it is the head being written.
      w_last_ok   = (r_count != '0) && !((r_count == CW'(1)) && w_deq);
      w_last_pc   = r_q_pc[w_tail_m1];
      w_last_slot = w_tail_m1;
`endif
      for (int s = 0; s < NUM_SRC; s++) begin
         w_wr[s]   = 1'b0;
         w_slot[s] = '0;
         if (bus.upd_valid[s] && w_upd_ready && !w_flush) begin
            w_wr[s] = 1'b1;
`ifdef BP_UPD_COALESCE_EN
            if (w_last_ok && (bus.upd_pc[s] == w_last_pc)) begin
               w_slot[s] = w_last_slot;
            end else begin
               w_slot[s]   = PW'(r_tail + w_n_alloc[PW-1:0]);
               w_n_alloc   = w_n_alloc + CW'(1);
               w_last_ok   = 1'b1;
               w_last_pc   = bus.upd_pc[s];
               w_last_slot = w_slot[s];
            end
`else
            w_slot[s] = PW'(r_tail + w_n_alloc[PW-1:0]);
            w_n_alloc = w_n_alloc + CW'(1);
`endif
         end
      end
   end

   assign w_cnt_next = r_count + w_n_alloc - CW'(w_deq);

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_INIT: begin
            if (bus.wr_ready && (r_sweep == LAST_SET)) begin
               w_next_state = S_IDLE;
            end
         end
         S_IDLE: begin
            if (w_flush) begin
               w_next_state = S_IDLE;
            end else if (w_n_alloc != '0) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_flush || (w_cnt_next == '0)) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_INIT;
      endcase
   end

   // FSM outputs; everything reads zero while reset is held.
   always_comb begin
      bus.wr_valid  = 1'b0;
      bus.wr_clear  = 1'b0;
      bus.wr_index  = '0;
      bus.wr_pc     = '0;
      bus.wr_target = '0;
      bus.wr_taken  = 1'b0;
      bus.upd_ready = w_upd_ready;
      bus.count     = reset ? '0 : r_count;
      if (!reset) begin
         case (r_state)
            S_INIT: begin
               bus.wr_valid = 1'b1;
               bus.wr_clear = 1'b1;
               bus.wr_index = r_sweep;
            end
            S_DRAIN: begin
               bus.wr_valid  = 1'b1;
               bus.wr_pc     = r_q_pc[r_head];
               bus.wr_target = r_q_tgt[r_head];
               bus.wr_taken  = r_q_tkn[r_head];
               bus.wr_index  = r_q_pc[r_head][2 +: IDXW];
            end
            default: ;
         endcase
      end
   end

   // Sweep counter and queue pointers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sweep <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if ((r_state == S_INIT) && bus.wr_ready) begin
            r_sweep <= r_sweep + IDXW'(1);
         end
         if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_deq) begin
               r_head <= r_head + PW'(1);
            end
            r_tail  <= r_tail + w_n_alloc[PW-1:0];
            r_count <= w_cnt_next;
         end
      end
   end

   // Queue storage; later sources win when two writes target one slot.
   always_ff @(posedge clock) begin
      for (int s = 0; s < NUM_SRC; s++) begin
         if (w_wr[s]) begin
            r_q_pc[w_slot[s]]  <= bus.upd_pc[s];
            r_q_tgt[w_slot[s]] <= bus.upd_target[s];
            r_q_tkn[w_slot[s]] <= bus.upd_taken[s];
         end
      end
   end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - self-checking bench for bp_update_scheduler
module tb_bp_update_scheduler;
   localparam int NUM_SRC  = 2;
   localparam int DEPTH    = 8;
   localparam int BTB_SETS = 64;
`ifdef BP_UPD_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tkn;
   } ent_t;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   ent_t m_q[$];
   bit   m_init;
   bit   m_rst;
   int   m_sweep;

   bp_update_scheduler_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .BTB_SETS(BTB_SETS)) bus ();

   bp_update_scheduler #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .BTB_SETS(BTB_SETS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs derived from the model: reset, clear sweep, queue empty or not.
   task automatic compare_all();
      int   sz;
      ent_t h;
      logic [31:0] idx;
      sz = m_q.size();
      if (m_rst) begin
         check("rst_wr_valid", bus.wr_valid, 0);
         check("rst_wr_clear", bus.wr_clear, 0);
         check("rst_wr_index", bus.wr_index, 0);
         check("rst_wr_pc", bus.wr_pc, 0);
         check("rst_wr_target", bus.wr_target, 0);
         check("rst_wr_taken", bus.wr_taken, 0);
         check("rst_upd_ready", bus.upd_ready, 0);
         check("rst_count", bus.count, 0);
      end else if (m_init) begin
         check("init_wr_valid", bus.wr_valid, 1);
         check("init_wr_clear", bus.wr_clear, 1);
         check("init_wr_index", bus.wr_index, m_sweep);
         check("init_wr_pc", bus.wr_pc, 0);
         check("init_wr_target", bus.wr_target, 0);
         check("init_wr_taken", bus.wr_taken, 0);
         check("init_upd_ready", bus.upd_ready, 0);
         check("init_count", bus.count, 0);
      end else if (sz > 0) begin
         h   = m_q[0];
         idx = {26'd0, h.pc[7:2]};
         check("drain_wr_valid", bus.wr_valid, 1);
         check("drain_wr_clear", bus.wr_clear, 0);
         check("drain_wr_index", bus.wr_index, idx);
         check("drain_wr_pc", bus.wr_pc, h.pc);
         check("drain_wr_target", bus.wr_target, h.tgt);
         check("drain_wr_taken", bus.wr_taken, h.tkn);
         check("drain_upd_ready", bus.upd_ready, (DEPTH - sz) >= NUM_SRC);
         check("drain_count", bus.count, sz);
      end else begin
         check("idle_wr_valid", bus.wr_valid, 0);
         check("idle_wr_clear", bus.wr_clear, 0);
         check("idle_upd_ready", bus.upd_ready, 1);
         check("idle_count", bus.count, 0);
      end
   endtask

   // Reference behaviour at a clock edge, in terms of a FIFO of updates.
   task automatic model_update();
      int   sz;
      bit   deq;
      bit   rdy;
      bit   last_ok;
      ent_t e;
      if (m_init) begin
         if (bus.wr_ready) begin
            if (m_sweep == BTB_SETS - 1) m_init = 1'b0;
            m_sweep = (m_sweep + 1) % BTB_SETS;
         end
      end else begin
         sz  = m_q.size();
         deq = (sz > 0) && bus.wr_ready;
         rdy = (DEPTH - sz) >= NUM_SRC;
         if (bus.flush) begin
            m_q.delete();
         end else begin
            last_ok = (sz > 0) && !(deq && sz == 1);
            for (int s = 0; s < NUM_SRC; s++) begin
               if (bus.upd_valid[s] && rdy) begin
                  if (COAL && last_ok && m_q[m_q.size()-1].pc == bus.upd_pc[s]) begin
                     m_q[m_q.size()-1].tgt = bus.upd_target[s];
                     m_q[m_q.size()-1].tkn = bus.upd_taken[s];
                  end else begin
                     e.pc  = bus.upd_pc[s];
                     e.tgt = bus.upd_target[s];
                     e.tkn = bus.upd_taken[s];
                     m_q.push_back(e);
                     last_ok = 1'b1;
                  end
               end
            end
            if (deq) void'(m_q.pop_front());
         end
      end
   endtask

   // Called at posedge+1 with inputs already applied.
   task automatic step();
      #3;
      compare_all();
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [31:0] p0, input logic t0,
                        input logic v1, input logic [31:0] p1, input logic t1,
                        input logic fl, input logic wr);
      bus.upd_valid     = {v1, v0};
      bus.upd_pc[0]     = p0;
      bus.upd_pc[1]     = p1;
      bus.upd_target[0] = $urandom;
      bus.upd_target[1] = $urandom;
      bus.upd_taken     = {t1, t0};
      bus.flush         = fl;
      bus.wr_ready      = wr;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_rst = 1'b1;
      #2;
      compare_all();
      @(posedge clock);
      #1;
      compare_all();
      m_q.delete();
      m_init  = 1'b1;
      m_sweep = 0;
      m_rst   = 1'b0;
      reset   = 1'b0;
   endtask

   task automatic drain_all();
      int n;
      n = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      while ((m_q.size() > 0) && (n < 50)) begin
         step();
         n++;
      end
      check("drain_bound", m_q.size(), 0);
   endtask

   initial begin
      int n;
      total   = 0;
      bad     = 0;
      reset   = 1'b1;
      m_init  = 1'b1;
      m_sweep = 0;
      m_rst   = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clock);
      #1;
      do_reset();

      // Sweep with back-pressure 1,0,1 then free-running; upd_valid ignored.
      drive(1, 32'h40, 0, 1, 32'h44, 1, 1, 1); step();
      drive(1, 32'h40, 0, 1, 32'h44, 1, 1, 0); step();
      check("sweep_hold_idx1", bus.wr_index, 1);
      drive(1, 32'h40, 0, 1, 32'h44, 1, 0, 1);
      n = 0;
      while (m_init && n < 200) begin step(); n++; end
      check("sweep_bound", m_init, 0);

      // Clean sweep, wr_ready held high: 64 clears then ready.
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < BTB_SETS; i++) step();
      check("sweep_done_ready", bus.upd_ready, 1);
      check("sweep_done_valid", bus.wr_valid, 0);

      // Ordering of two sources in one cycle.
      drive(1, 32'h100, 1, 1, 32'h200, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      check("order_first_pc", bus.wr_pc, 32'h100);
      step();
      check("order_second_pc", bus.wr_pc, 32'h200);
      check("order_second_idx", bus.wr_index, 0);
      step();

      // Full queue under back-pressure.
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h1000 + 8 * i, 0, 1, 32'h1004 + 8 * i, 1, 0, 0);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      check("full_count", bus.count, DEPTH);
      check("full_ready", bus.upd_ready, 0);
      step();
      drive(1, 32'h2000, 0, 1, 32'h2004, 0, 0, 0);
      check("full_minus1_count", bus.count, DEPTH - 1);
      check("full_minus1_ready", bus.upd_ready, 0);
      step();
      drain_all();

      // Flush with dual enqueue at count=5.
      drive(1, 32'h1000, 0, 1, 32'h1004, 1, 0, 0); step();
      drive(1, 32'h1008, 1, 1, 32'h100c, 0, 0, 0); step();
      drive(1, 32'h1010, 1, 0, 0, 0, 0, 0); step();
      check("preflush_count", bus.count, 5);
      drive(1, 32'h1014, 0, 1, 32'h1018, 1, 1, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("flush_count", bus.count, 0);
      check("flush_wr_valid", bus.wr_valid, 0);
      step();

      // Back-to-back updates to one PC.
      drive(1, 32'h300, 0, 0, 0, 0, 0, 0); step();
      drive(1, 32'h300, 1, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("coal_count", bus.count, COAL ? 1 : 2);
      check("coal_taken", bus.wr_taken, COAL ? 1 : 0);
      step();
      drain_all();

      // Randomized traffic with a small PC pool to exercise matches.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), 32'h300 + 4 * $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 1), 32'h300 + 4 * $urandom_range(0, 3), $urandom_range(0, 1),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
         step();
      end

      // Reset mid-drain, then a sweep.
      drive(1, 32'h500, 0, 1, 32'h504, 1, 0, 0); step();
      step();
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < BTB_SETS + 2; i++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
